// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and the axis phase encoding
// used by both the horizontal and the vertical timing FSM.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_SYNC_POL = 1'b0;

    localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
    localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

    // Both axes walk through the same four phases, so they share one encoding.
    typedef enum logic [1:0] {
        PH_ACT   = 2'd0,
        PH_FRONT = 2'd1,
        PH_SYNC  = 2'd2,
        PH_BACK  = 2'd3
    } axis_phase_t;

    typedef axis_phase_t h_phase_t;
    typedef axis_phase_t v_phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA timing axis: a 0..TOTAL-1 counter with an active/front/sync/back
// phase FSM. The count advances when en and wrap_in are both high; wrap_in
// is the carry from a lower axis and is tied high when there is none.
// wrap_out flags the step that takes the count from TOTAL-1 back to 0.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE   = DEF_H_ACTIVE,
    parameter int FP       = DEF_H_FP,
    parameter int SYNC     = DEF_H_SYNC,
    parameter int BP       = DEF_H_BP,
    parameter bit SYNC_POL = DEF_SYNC_POL
)(
    input  logic       clk_nexys,
    input  logic       rst,
    input  logic       en,
    input  logic       wrap_in,
    output logic [9:0] cnt,
    output logic       sync,
    output logic       active,
    output logic       wrap_out
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    if (TOTAL > 1023) begin : g_total_too_wide
        $error("vga_axis_counter: ACTIVE+FP+SYNC+BP = %0d exceeds 10-bit limit 1023", TOTAL);
    end

    localparam logic [9:0] ACT_LAST   = 10'(ACTIVE - 1);
    localparam logic [9:0] FRONT_LAST = 10'(ACTIVE + FP - 1);
    localparam logic [9:0] SYNC_LAST  = 10'(ACTIVE + FP + SYNC - 1);
    localparam logic [9:0] LAST       = 10'(TOTAL - 1);

    axis_phase_t phase;
    axis_phase_t phase_next;
    logic [9:0]  cnt_next;
    logic        step;

    assign step     = en & wrap_in;
    assign wrap_out = step && (cnt == LAST);

    // Next count and next phase; phase changes when the count leaves a region.
    always_comb begin
        cnt_next   = cnt;
        phase_next = phase;
        if (step) begin
            cnt_next = (cnt == LAST) ? 10'd0 : cnt + 10'd1;
            case (phase)
                PH_ACT:   if (cnt == ACT_LAST)   phase_next = PH_FRONT;
                PH_FRONT: if (cnt == FRONT_LAST) phase_next = PH_SYNC;
                PH_SYNC:  if (cnt == SYNC_LAST)  phase_next = PH_BACK;
                PH_BACK:  if (cnt == LAST)       phase_next = PH_ACT;
                default:  phase_next = PH_ACT;
            endcase
        end
    end

    // State register; sync/active are registered from the next phase so they move with cnt.
    always_ff @(posedge clk_nexys or posedge rst) begin
        if (rst) begin
            cnt    <= 10'd0;
            phase  <= PH_ACT;
            sync   <= ~SYNC_POL;
            active <= 1'b1;
        end else begin
            cnt    <= cnt_next;
            phase  <= phase_next;
            sync   <= (phase_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            active <= (phase_next == PH_ACT);
        end
    end

endmodule

// File: rtl/vga_sync_rx.sv
// VGA 640x480@60 Hz sync generator running on clk_nexys, stepped by rising
// edges of the 25 MHz pixel_rate square wave from the clock divider.
// Optional feature: define VGA_FRAME_TICK_EN to add the frame_tick output,
// a pulse alongside pix_tick whenever the coordinates become (0,0).
module vga_sync_rx
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = DEF_SYNC_POL
)(
    input  logic       clk_nexys,
    input  logic       rst,
    input  logic       pixel_rate,
    output logic       pix_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic       frame_tick
`endif
);

    logic pr_q;
    logic tick;
    logic started;
    logic h_active;
    logic v_active;
    logic h_wrap;
    logic v_wrap;

    // pr_q comes out of reset high so a pixel_rate already high at release is not a rising edge.
    assign tick = pixel_rate & ~pr_q;

    // Edge-detect history, pix_tick delayed to line up with new coordinates, and first-tick flag.
    always_ff @(posedge clk_nexys or posedge rst) begin
        if (rst) begin
            pr_q     <= 1'b1;
            pix_tick <= 1'b0;
            started  <= 1'b0;
        end else begin
            pr_q     <= pixel_rate;
            pix_tick <= tick;
            started  <= started | tick;
        end
    end

    vga_axis_counter #(
        .ACTIVE   (H_ACTIVE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .SYNC_POL (SYNC_POL)
    ) u_h_axis (
        .clk_nexys (clk_nexys),
        .rst       (rst),
        .en        (tick),
        .wrap_in   (1'b1),
        .cnt       (pixel_x),
        .sync      (hsync),
        .active    (h_active),
        .wrap_out  (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE   (V_ACTIVE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_v_axis (
        .clk_nexys (clk_nexys),
        .rst       (rst),
        .en        (h_wrap),
        .wrap_in   (1'b1),
        .cnt       (pixel_y),
        .sync      (vsync),
        .active    (v_active),
        .wrap_out  (v_wrap)
    );

    // Visible area is held dark until the first pixel tick after reset.
    assign video_on = started & h_active & v_active;

`ifdef VGA_FRAME_TICK_EN
    // The vertical wrap only happens on the tick that also wraps horizontally: next coords are (0,0).
    always_ff @(posedge clk_nexys or posedge rst) begin
        if (rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= v_wrap;
        end
    end
`else
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// Self-checking bench for vga_sync_rx. One instance uses the real 640x480
// timing; a second, shrunken instance (16x12 totals) lets whole frames,
// vsync and the (799,524)-style double wrap be exercised in a short run.
// Both share clock, reset and pixel_rate, so a single tick count drives
// the reference model for both.
module tb_vga_sync_rx;

    localparam int S_HA = 8;
    localparam int S_HF = 2;
    localparam int S_HS = 3;
    localparam int S_HB = 3;
    localparam int S_VA = 6;
    localparam int S_VF = 2;
    localparam int S_VS = 2;
    localparam int S_VB = 2;
    localparam int S_FRAME = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);
    localparam int D_FRAME = 800 * 525;

    logic       clk_nexys = 1'b0;
    logic       rst = 1'b0;
    logic       pixel_rate = 1'b0;

    logic       d_tick, d_hs, d_vs, d_von;
    logic [9:0] d_x, d_y;
    logic       s_tick, s_hs, s_vs, s_von;
    logic [9:0] s_x, s_y;
`ifdef VGA_FRAME_TICK_EN
    logic       d_frame, s_frame;
`endif

    vga_sync_rx dut (
        .clk_nexys  (clk_nexys),
        .rst        (rst),
        .pixel_rate (pixel_rate),
        .pix_tick   (d_tick),
        .hsync      (d_hs),
        .vsync      (d_vs),
        .video_on   (d_von),
        .pixel_x    (d_x),
        .pixel_y    (d_y)
`ifdef VGA_FRAME_TICK_EN
        ,
        .frame_tick (d_frame)
`endif
    );

    vga_sync_rx #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
        .SYNC_POL (1'b0)
    ) dut_small (
        .clk_nexys  (clk_nexys),
        .rst        (rst),
        .pixel_rate (pixel_rate),
        .pix_tick   (s_tick),
        .hsync      (s_hs),
        .vsync      (s_vs),
        .video_on   (s_von),
        .pixel_x    (s_x),
        .pixel_y    (s_y)
`ifdef VGA_FRAME_TICK_EN
        ,
        .frame_tick (s_frame)
`endif
    );

    always #5 clk_nexys = ~clk_nexys;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;
    int d_tick_count = 0;
    int s_frame_count = 0;

    // Reference model state: pixel ticks seen since reset, plus the pulses they imply.
    int m_n;
    bit m_prev, m_tick, m_started, m_frame_d, m_frame_s;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Expected {pix_tick,hsync,vsync,video_on,x,y} after n pixel ticks on a given timing.
    function automatic logic [23:0] expectVec(input int n, input bit tick, input bit started,
                                              input int ha, input int hf, input int hsw, input int hb,
                                              input int va, input int vf, input int vsw, input int vb);
        int htot, vtot, x, y;
        bit hs_on, vs_on, vis;
        htot  = ha + hf + hsw + hb;
        vtot  = va + vf + vsw + vb;
        x     = n % htot;
        y     = (n / htot) % vtot;
        hs_on = (x >= ha + hf) && (x < ha + hf + hsw);
        vs_on = (y >= va + vf) && (y < va + vf + vsw);
        vis   = started && (x < ha) && (y < va);
        return {tick, ~hs_on, ~vs_on, vis, 10'(x), 10'(y)};
    endfunction

    // Model: a pixel tick is a pixel_rate rising edge seen at a clock edge since reset.
    always @(posedge clk_nexys or posedge rst) begin
        if (rst) begin
            m_prev    <= 1'b1;
            m_n       <= 0;
            m_tick    <= 1'b0;
            m_started <= 1'b0;
            m_frame_d <= 1'b0;
            m_frame_s <= 1'b0;
        end else begin
            m_prev    <= pixel_rate;
            m_tick    <= pixel_rate && !m_prev;
            m_frame_d <= pixel_rate && !m_prev && (((m_n + 1) % D_FRAME) == 0);
            m_frame_s <= pixel_rate && !m_prev && (((m_n + 1) % S_FRAME) == 0);
            if (pixel_rate && !m_prev) begin
                m_n       <= m_n + 1;
                m_started <= 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk_nexys) begin
        if (check_en) begin
            checkOutput("default_outputs", 32'({d_tick, d_hs, d_vs, d_von, d_x, d_y}),
                        32'(expectVec(m_n, m_tick, m_started, 640, 16, 96, 48, 480, 10, 2, 33)));
            checkOutput("small_outputs", 32'({s_tick, s_hs, s_vs, s_von, s_x, s_y}),
                        32'(expectVec(m_n, m_tick, m_started, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB)));
            if (d_tick) d_tick_count++;
`ifdef VGA_FRAME_TICK_EN
            checkOutput("default_frame_tick", 32'(d_frame), 32'(m_frame_d));
            checkOutput("small_frame_tick", 32'(s_frame), 32'(m_frame_s));
            if (s_frame) s_frame_count++;
`endif
        end
    end

    // n pixel ticks: pixel_rate high two cycles, low two cycles, as the divider makes it.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk_nexys); #1 pixel_rate = 1'b1;
            @(posedge clk_nexys); #1;
            @(posedge clk_nexys); #1 pixel_rate = 1'b0;
            @(posedge clk_nexys); #1;
        end
    endtask

    // Hold reset with pixel_rate toggling, release with pixel_rate high, then settle low.
    task automatic resetSequence();
        rst = 1'b1;
        repeat (6) begin
            @(posedge clk_nexys); #1 pixel_rate = ~pixel_rate;
        end
        @(posedge clk_nexys); #1 pixel_rate = 1'b1;
        @(posedge clk_nexys); #1 rst = 1'b0;
        @(posedge clk_nexys); #1;
        checkOutput("no_tick_at_release", 32'(d_tick), 32'd0);
        checkOutput("x_at_release", 32'(d_x), 32'd0);
        pixel_rate = 1'b0;
        repeat (2) @(posedge clk_nexys);
        #1;
    endtask

    initial begin
        int c0;
        #2 rst = 1'b1;
        @(posedge clk_nexys); #1;
        check_en = 1'b1;
        checkOutput("reset_x", 32'(d_x), 32'd0);
        checkOutput("reset_y", 32'(d_y), 32'd0);
        checkOutput("reset_hsync", 32'(d_hs), 32'd1);
        checkOutput("reset_vsync", 32'(d_vs), 32'd1);
        checkOutput("reset_video_on", 32'(d_von), 32'd0);
        checkOutput("reset_pix_tick", 32'(d_tick), 32'd0);
        resetSequence();

        applyStimulus(1);
        checkOutput("x_after_1", 32'(d_x), 32'd1);
        checkOutput("video_on_after_1", 32'(d_von), 32'd1);
        c0 = d_tick_count;
        applyStimulus(10);
        checkOutput("ticks_in_10", 32'(d_tick_count - c0), 32'd10);
        applyStimulus(628);
        checkOutput("x_639", 32'(d_x), 32'd639);
        checkOutput("video_on_639", 32'(d_von), 32'd1);
        applyStimulus(1);
        checkOutput("video_on_640", 32'(d_von), 32'd0);
        applyStimulus(15);
        checkOutput("hsync_655", 32'(d_hs), 32'd1);
        applyStimulus(1);
        checkOutput("hsync_656", 32'(d_hs), 32'd0);
        applyStimulus(95);
        checkOutput("hsync_751", 32'(d_hs), 32'd0);
        applyStimulus(1);
        checkOutput("hsync_752", 32'(d_hs), 32'd1);
        applyStimulus(47);
        checkOutput("x_799", 32'(d_x), 32'd799);
        checkOutput("y_before_wrap", 32'(d_y), 32'd0);
        applyStimulus(1);
        checkOutput("x_wrap", 32'(d_x), 32'd0);
        checkOutput("y_after_wrap", 32'(d_y), 32'd1);
        checkOutput("small_y_at_800", 32'(s_y), 32'd2);

        applyStimulus(96);
        checkOutput("small_y_8", 32'(s_y), 32'd8);
        checkOutput("small_vsync_y8", 32'(s_vs), 32'd0);

        // Freeze pixel_rate high, then low: exactly one tick from the initial rise.
        c0 = d_tick_count;
        @(posedge clk_nexys); #1 pixel_rate = 1'b1;
        repeat (100) @(posedge clk_nexys);
        #1 pixel_rate = 1'b0;
        repeat (20) @(posedge clk_nexys);
        #1;
        checkOutput("stall_x", 32'(d_x), 32'd97);
        checkOutput("stall_ticks", 32'(d_tick_count - c0), 32'd1);

        applyStimulus(203);
        checkOutput("x_300", 32'(d_x), 32'd300);
        checkOutput("y_1", 32'(d_y), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midreset_x", 32'(d_x), 32'd0);
        checkOutput("midreset_y", 32'(d_y), 32'd0);
        checkOutput("midreset_hsync", 32'(d_hs), 32'd1);
        checkOutput("midreset_video_on", 32'(d_von), 32'd0);
        resetSequence();
        applyStimulus(5);
        checkOutput("resume_x", 32'(d_x), 32'd5);
        checkOutput("resume_y", 32'(d_y), 32'd0);

        applyStimulus(186);
        checkOutput("small_x_last", 32'(s_x), 32'd15);
        checkOutput("small_y_last", 32'(s_y), 32'd11);
        applyStimulus(1);
        checkOutput("small_x_double_wrap", 32'(s_x), 32'd0);
        checkOutput("small_y_double_wrap", 32'(s_y), 32'd0);
`ifdef VGA_FRAME_TICK_EN
        checkOutput("small_frame_count", 32'(s_frame_count), 32'd6);
`endif
        repeat (4) @(posedge clk_nexys);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
